// File: rtl/ring_inject_pkg.sv
// Shared ring definitions: control word width, valid-bit index, flit type.
// Optional statistics are built when RING_INJECT_STATS_EN is defined.
`ifndef RING_CTRL_W
`define RING_CTRL_W 144
`endif

package ring_inject_pkg;
  localparam int CONTROL_W = `RING_CTRL_W;
  localparam int VALID_BIT = 143;

  typedef logic [CONTROL_W-1:0] control_t;

  function automatic logic flit_valid(control_t c);
    return c[VALID_BIT];
  endfunction
endpackage

// File: rtl/ring_inject_stage_fifo.sv
// Injection FIFO: power-of-two ring buffer with registered occupancy.
// Pointers wrap naturally modulo DEPTH.
module inj_fifo
  import ring_inject_pkg::*;
#(
  parameter int DEPTH = 4,
  parameter int W     = `RING_CTRL_W,
  localparam int AW   = $clog2(DEPTH),
  localparam int CW   = AW + 1
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          push,
  input  logic          pop,
  input  logic [W-1:0]  din,
  output logic [W-1:0]  dout,
  output logic          full,
  output logic          empty,
  output logic [CW-1:0] count
);

  logic [W-1:0]  mem [DEPTH];
  logic [AW-1:0] wr_ptr;
  logic [AW-1:0] rd_ptr;
  logic          do_push;
  logic          do_pop;

  assign full    = (count == CW'(DEPTH));
  assign empty   = (count == '0);
  assign do_push = push && !full;
  assign do_pop  = pop && !empty;
  assign dout    = mem[rd_ptr];

  always_ff @(posedge clk) begin
    if (do_push) mem[wr_ptr] <= din;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      if (do_push) wr_ptr <= wr_ptr + 1'b1;
      if (do_pop)  rd_ptr <= rd_ptr + 1'b1;
      unique case ({do_push, do_pop})
        2'b10:   count <= count + 1'b1;
        2'b01:   count <= count - 1'b1;
        default: count <= count;
      endcase
    end
  end

endmodule

// File: rtl/ring_inject_stage.sv
// Ring injection stage: through traffic wins, local flits fill empty slots.
// Define RING_INJECT_STATS_EN to add inj_count/blk_count statistics.
module ring_inject_stage
  import ring_inject_pkg::*;
#(
  parameter int DEPTH       = 4,
  parameter int STALL_LIMIT = 16
) (
  input  logic                   clk,
  input  logic                   rst,
  input  logic [`RING_CTRL_W-1:0] port0_ci,
  output logic [`RING_CTRL_W-1:0] port0_co,
  input  logic [`RING_CTRL_W-1:0] inj_ci,
  input  logic                   inj_valid,
  output logic                   inj_ready,
  output logic                   inj_starve
`ifdef RING_INJECT_STATS_EN
  ,
  output logic [15:0]            inj_count,
  output logic [15:0]            blk_count
`endif
);

  localparam int CW = $clog2(DEPTH) + 1;
  localparam int SW = $clog2(STALL_LIMIT + 1);
  localparam logic [SW-1:0] LIM = SW'(STALL_LIMIT);

  control_t      head;
  control_t      co_nx;
  logic          full;
  logic          empty;
  logic [CW-1:0] count;
  logic          ring_v;
  logic          pop;
  logic          push;
  logic          blocked;
  logic [SW-1:0] stall;
  logic [SW-1:0] stall_nx;

  assign ring_v    = flit_valid(port0_ci);
  assign inj_ready = (count < CW'(DEPTH));
  assign push      = inj_valid && !full;
  assign pop       = !ring_v && !empty;
  assign blocked   = ring_v && !empty;

  inj_fifo #(
    .DEPTH (DEPTH),
    .W     (CONTROL_W)
  ) u_fifo (
    .clk   (clk),
    .rst   (rst),
    .push  (push),
    .pop   (pop),
    .din   (inj_ci),
    .dout  (head),
    .full  (full),
    .empty (empty),
    .count (count)
  );

  always_comb begin
    co_nx    = '0;
    stall_nx = '0;
    unique case (1'b1)
      ring_v: co_nx = port0_ci;
      pop:    co_nx = head;
      default: co_nx = '0;
    endcase
    if (blocked) stall_nx = (stall == LIM) ? stall : stall + 1'b1;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      port0_co   <= '0;
      stall      <= '0;
      inj_starve <= 1'b0;
    end else begin
      port0_co   <= co_nx;
      stall      <= stall_nx;
      inj_starve <= (stall_nx == LIM);
    end
  end

`ifdef RING_INJECT_STATS_EN
  always_ff @(posedge clk) begin
    if (rst) begin
      inj_count <= '0;
      blk_count <= '0;
    end else begin
      if (pop && inj_count != 16'hFFFF)     inj_count <= inj_count + 1'b1;
      if (blocked && blk_count != 16'hFFFF) blk_count <= blk_count + 1'b1;
    end
  end
`endif

endmodule
